// File: rtl/change_dispenser_ctrl.sv
// Change dispenser: greedy 50/10/1 breakdown of the change owed, one coin per hopper req/ack handshake.
// Define CHANGE_COIN5_EN to add the 5-unit coin (coin_type 00) between 10 and 1.
module change_dispenser_ctrl #(
  parameter logic [23:0] GAP_CYCLES  = 24'd10_000_000,
  parameter logic [23:0] ACK_TIMEOUT = 24'd16_000_000
) (
  input  logic       fpga_clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] amount,
  input  logic       abort,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic [1:0] coin_type,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [6:0] remaining,
  output logic [3:0] coins_issued
);

`ifdef CHANGE_COIN5_EN
  localparam bit COIN5_EN = 1'b1;
`else
  localparam bit COIN5_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [1:0] COIN_5  = 2'b00;
  localparam logic [1:0] COIN_1  = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;
  localparam logic [1:0] COIN_50 = 2'b11;

  state_t      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [6:0]  remaining_q, remaining_d;
  logic [3:0]  coins_q, coins_d;
  logic [1:0]  coin_type_q, coin_type_d;
  logic        fault_q, fault_d;
  logic        coin_req_q, busy_q, done_q;

  function automatic logic [6:0] coin_value(input logic [1:0] t);
    case (t)
      COIN_50: coin_value = 7'd50;
      COIN_10: coin_value = 7'd10;
      COIN_1:  coin_value = 7'd1;
      default: coin_value = 7'd5;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    coins_d     = coins_q;
    coin_type_d = coin_type_q;
    fault_d     = fault_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = (amount > 7'd99) ? 7'd99 : amount;
          coins_d     = 4'd0;
          fault_d     = 1'b0;
          state_d     = S_SELECT;
        end
      end

      S_SELECT: begin
        timer_d = 24'd0;
        state_d = S_REQ;
        if (remaining_q >= 7'd50) begin
          coin_type_d = COIN_50;
        end else if (remaining_q >= 7'd10) begin
          coin_type_d = COIN_10;
        end else if (COIN5_EN && (remaining_q >= 7'd5)) begin
          coin_type_d = COIN_5;
        end else if (remaining_q != 7'd0) begin
          coin_type_d = COIN_1;
        end else begin
          state_d = S_DONE;
        end
      end

      S_REQ: begin
        if (coin_ack) begin
          remaining_d = remaining_q - coin_value(coin_type_q);
          coins_d     = (coins_q == 4'd15) ? coins_q : coins_q + 4'd1;
          timer_d     = 24'd0;
          state_d     = S_GAP;
        end else if (timer_q == ACK_TIMEOUT - 24'd1) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end

      S_GAP: begin
        if (timer_q == GAP_CYCLES - 24'd1) begin
          state_d = S_SELECT;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides only the state; a coin acked in the same cycle is still counted above.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= 24'd0;
      remaining_q <= 7'd0;
      coins_q     <= 4'd0;
      coin_type_q <= 2'b00;
      fault_q     <= 1'b0;
      coin_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      coins_q     <= coins_d;
      coin_type_q <= coin_type_d;
      fault_q     <= fault_d;
      coin_req_q  <= (state_d == S_REQ);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign coin_req     = coin_req_q;
  assign coin_type    = coin_type_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fault        = fault_q;
  assign remaining    = remaining_q;
  assign coins_issued = coins_q;

endmodule
